// File: rtl/posit_decoder_pipe_if.sv
// Operand/result bundle for the pipelined posit decoder: upstream operand
// handshake plus the decoded-field result handshake.
interface posit_decoder_pipe_if #(
  parameter int N  = 64,
  parameter int ES = 4,
  parameter int RS = $clog2(N) + 1,
  parameter int FS = N - ES - 3
);
  logic [N-1:0]         in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 out_sign;
  logic signed [RS-1:0] out_regime;
  logic [ES-1:0]        out_exp;
  logic [FS-1:0]        out_frac;
  logic                 out_zero;
  logic                 out_nar;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_sign, out_regime, out_exp, out_frac,
           out_zero, out_nar, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_sign, out_regime, out_exp, out_frac,
           out_zero, out_nar, out_valid
  );
endinterface

// File: rtl/posit_decoder_pipe.sv
// Three-stage posit decoder: sign/magnitude, regime run detection, then
// exponent/fraction split. Each stage loads whenever it is empty or draining.
module posit_decoder_pipe #(
  parameter int N  = 64,
  parameter int ES = 4,
  parameter int RS = $clog2(N) + 1,
  parameter int FS = N - ES - 3
) (
  input  logic                clk,
  input  logic                rst,
  posit_decoder_pipe_if.slave pd
);

  // Length of the run of bits equal to the MSB of b, scanning downward.
  function automatic logic [RS-1:0] lead_run(input logic [N-2:0] b);
    logic [RS-1:0] m;
    logic          done;
    m    = RS'(N - 1);
    done = 1'b0;
    for (int i = N - 3; i >= 0; i--) begin
      if (!done && (b[i] != b[N-2])) begin
        m    = RS'(N - 2 - i);
        done = 1'b1;
      end
    end
    return m;
  endfunction

  logic en1, en2, en3;

  logic                 vld_p1_q, vld_p2_q, vld_p3_q;
  logic                 sign_p1_q, sign_p2_q, sign_p3_q;
  logic                 zero_p1_q, zero_p2_q, zero_p3_q;
  logic                 nar_p1_q, nar_p2_q, nar_p3_q;
  logic [N-2:0]         body_p1_q, body_p1_d;
  logic [RS-1:0]        run_p2_d;
  logic signed [RS-1:0] k_p2_q, k_p2_d, k_p3_q;
  logic [N-4:0]         rem_p2_q, rem_p2_d;
  logic [ES-1:0]        exp_p3_q;
  logic [FS-1:0]        frac_p3_q;

  assign en3         = !vld_p3_q || pd.out_ready;
  assign en2         = !vld_p2_q || en3;
  assign en1         = !vld_p1_q || en2;
  assign pd.in_ready = en1;

  // Stage 1: sign and two's-complement magnitude body
  assign body_p1_d = pd.in_data[N-1] ? -pd.in_data[N-2:0] : pd.in_data[N-2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      sign_p1_q <= 1'b0;
      body_p1_q <= '0;
      zero_p1_q <= 1'b0;
      nar_p1_q  <= 1'b0;
    end else if (en1) begin
      vld_p1_q <= pd.in_valid;
      if (pd.in_valid) begin
        sign_p1_q <= pd.in_data[N-1];
        body_p1_q <= body_p1_d;
        zero_p1_q <= (pd.in_data == '0);
        nar_p1_q  <= (pd.in_data == {1'b1, {(N-1){1'b0}}});
      end
    end
  end

  // Stage 2: regime from the leading run; drop run and terminator bit.
  // The two low bits of the shifted body never reach exp/frac.
  assign run_p2_d = lead_run(body_p1_q);
  assign rem_p2_d = (N-3)'((body_p1_q << (run_p2_d + RS'(1))) >> 2);

  always_comb begin
    k_p2_d = '0;
    if (!(zero_p1_q || nar_p1_q)) begin
      if (body_p1_q[N-2]) k_p2_d = signed'(run_p2_d - RS'(1));
      else                k_p2_d = -signed'(run_p2_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2_q  <= 1'b0;
      sign_p2_q <= 1'b0;
      k_p2_q    <= '0;
      rem_p2_q  <= '0;
      zero_p2_q <= 1'b0;
      nar_p2_q  <= 1'b0;
    end else if (en2) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        sign_p2_q <= sign_p1_q;
        k_p2_q    <= k_p2_d;
        rem_p2_q  <= rem_p2_d;
        zero_p2_q <= zero_p1_q;
        nar_p2_q  <= nar_p1_q;
      end
    end
  end

  // Stage 3: exponent and left-aligned fraction split
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p3_q  <= 1'b0;
      sign_p3_q <= 1'b0;
      k_p3_q    <= '0;
      exp_p3_q  <= '0;
      frac_p3_q <= '0;
      zero_p3_q <= 1'b0;
      nar_p3_q  <= 1'b0;
    end else if (en3) begin
      vld_p3_q <= vld_p2_q;
      if (vld_p2_q) begin
        sign_p3_q <= sign_p2_q;
        k_p3_q    <= k_p2_q;
        exp_p3_q  <= rem_p2_q[N-4 -: ES];
        frac_p3_q <= rem_p2_q[FS-1:0];
        zero_p3_q <= zero_p2_q;
        nar_p3_q  <= nar_p2_q;
      end
    end
  end

  assign pd.out_valid  = vld_p3_q;
  assign pd.out_sign   = sign_p3_q;
  assign pd.out_regime = k_p3_q;
  assign pd.out_exp    = exp_p3_q;
  assign pd.out_frac   = frac_p3_q;
  assign pd.out_zero   = zero_p3_q;
  assign pd.out_nar    = nar_p3_q;

endmodule

// File: tb/tb_posit_decoder_pipe.sv
// Directed bench for posit_decoder_pipe at N=16, ES=1: decode corpus,
// streaming, backpressure, bubble collapse and mid-stream reset.
module tb_posit_decoder_pipe;
  localparam int N  = 16;
  localparam int ES = 1;
  localparam int NV = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  posit_decoder_pipe_if #(.N(N), .ES(ES)) pd();
  posit_decoder_pipe #(.N(N), .ES(ES)) dut (.clk(clk), .rst(rst), .pd(pd));

  int errors = 0;
  int checks = 0;

  logic [15:0] cdin[NV];
  logic [20:0] cexp[NV];
  logic [20:0] obs;
  assign obs = {pd.out_sign, pd.out_regime, pd.out_exp, pd.out_frac, pd.out_zero, pd.out_nar};

  task automatic set_vec(input int i, input logic [15:0] d, input logic s,
                         input logic signed [4:0] k, input logic e,
                         input logic [11:0] f, input logic z, input logic n);
    cdin[i] = d;
    cexp[i] = {s, k, e, f, z, n};
  endtask

  task automatic init_corpus();
    set_vec(0, 16'h4000, 1'b0,  5'sd0,  1'b0, 12'h000, 1'b0, 1'b0);
    set_vec(1, 16'h5A00, 1'b0,  5'sd0,  1'b1, 12'hA00, 1'b0, 1'b0);
    set_vec(2, 16'h7FFF, 1'b0,  5'sd14, 1'b0, 12'h000, 1'b0, 1'b0);
    set_vec(3, 16'h0001, 1'b0, -5'sd14, 1'b0, 12'h000, 1'b0, 1'b0);
    set_vec(4, 16'hC000, 1'b1,  5'sd0,  1'b0, 12'h000, 1'b0, 1'b0);
    set_vec(5, 16'h0000, 1'b0,  5'sd0,  1'b0, 12'h000, 1'b1, 1'b0);
    set_vec(6, 16'h8000, 1'b1,  5'sd0,  1'b0, 12'h000, 1'b0, 1'b1);
    set_vec(7, 16'hA600, 1'b1,  5'sd0,  1'b1, 12'hA00, 1'b0, 1'b0);
    set_vec(8, 16'h6800, 1'b0,  5'sd1,  1'b1, 12'h000, 1'b0, 1'b0);
    set_vec(9, 16'h1B00, 1'b0, -5'sd2,  1'b1, 12'h600, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pd.in_valid = 1'b1;
    pd.in_data = 16'h5A00;
    pd.out_ready = 1'b0;
    #12;
    checks++;
    if (pd.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", pd.out_valid);
    end
    checks++;
    if (obs !== 21'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 000000", obs);
    end
    @(negedge clk);
    pd.in_valid = 1'b0;
    pd.in_data = '0;
    rst = 1'b0;
    #1;
    checks++;
    if (pd.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", pd.in_ready);
    end
    checks++;
    if (pd.out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_out_valid: got %b expected 0", pd.out_valid);
    end
  endtask

  task automatic test_corpus();
    int lat;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      pd.in_data = cdin[i];
      pd.in_valid = 1'b1;
      pd.out_ready = 1'b1;
      #1;
      checks++;
      if (pd.in_ready !== 1'b1) begin
        errors++; $display("FAIL corpus_in_ready[%0d]: got %b expected 1", i, pd.in_ready);
      end
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      pd.in_valid = 1'b0;
      pd.in_data = '0;
      while (pd.out_valid !== 1'b1 && lat < 8) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
      checks++;
      if (lat !== 3) begin
        errors++; $display("FAIL corpus_latency[%0d]: got %0d expected 3", i, lat);
      end
      checks++;
      if (obs !== cexp[i]) begin
        errors++; $display("FAIL corpus_decode[%h]: got %h expected %h", cdin[i], obs, cexp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int rx = 0;
    int first = -1;
    int gaps = 0;
    pd.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pd.out_valid === 1'b1) begin
        if (first < 0) first = c;
        checks++;
        if (rx >= 8 || obs !== cexp[rx % NV]) begin
          errors++; $display("FAIL stream_data[%0d]: got %h expected %h", rx, obs, cexp[rx % NV]);
        end
        rx++;
      end else if (first >= 0 && rx < 8) begin
        gaps++;
      end
      if (c < 8) begin
        pd.in_valid = 1'b1;
        pd.in_data = cdin[c];
      end else begin
        pd.in_valid = 1'b0;
        pd.in_data = '0;
      end
      #1;
      if (c < 8) begin
        checks++;
        if (pd.in_ready !== 1'b1) begin
          errors++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", c, pd.in_ready);
        end
      end
    end
    checks++;
    if (first !== 3) begin
      errors++; $display("FAIL stream_first_out: got cycle %0d expected 3", first);
    end
    checks++;
    if (rx !== 8) begin
      errors++; $display("FAIL stream_count: got %0d expected 8", rx);
    end
    checks++;
    if (gaps !== 0) begin
      errors++; $display("FAIL stream_gaps: got %0d expected 0", gaps);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int rx = 0;
    logic [20:0] held;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      pd.out_ready = 1'b0;
      pd.in_valid = 1'b1;
      pd.in_data = cdin[acc];
      #1;
      if (pd.in_ready === 1'b1) acc++;
    end
    @(negedge clk);
    pd.in_valid = 1'b0;
    pd.in_data = '0;
    #1;
    checks++;
    if (acc !== 3) begin
      errors++; $display("FAIL bp_accepted: got %0d expected 3", acc);
    end
    checks++;
    if (pd.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_in_ready: got %b expected 0", pd.in_ready);
    end
    checks++;
    if (pd.out_valid !== 1'b1 || obs !== cexp[0]) begin
      errors++; $display("FAIL bp_head: got v=%b %h expected v=1 %h", pd.out_valid, obs, cexp[0]);
    end
    held = obs;
    repeat (2) @(negedge clk);
    checks++;
    if (pd.out_valid !== 1'b1 || obs !== held) begin
      errors++; $display("FAIL bp_hold: got v=%b %h expected v=1 %h", pd.out_valid, obs, held);
    end
    pd.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (pd.out_valid === 1'b1) begin
        checks++;
        if (rx >= 3 || obs !== cexp[rx % NV]) begin
          errors++; $display("FAIL bp_drain[%0d]: got %h expected %h", rx, obs, cexp[rx % NV]);
        end
        rx++;
      end
      @(negedge clk);
    end
    checks++;
    if (rx !== 3) begin
      errors++; $display("FAIL bp_drain_count: got %0d expected 3", rx);
    end
  endtask

  task automatic test_bubble();
    int order[3] = '{8, 9, 1};
    logic vpat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int dsel[5] = '{8, 0, 0, 9, 1};
    int rx = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      pd.out_ready = 1'b0;
      pd.in_valid = vpat[c];
      pd.in_data = vpat[c] ? cdin[dsel[c]] : 16'h0;
      #1;
      checks++;
      if (pd.in_ready !== 1'b1) begin
        errors++; $display("FAIL bubble_in_ready[%0d]: got %b expected 1", c, pd.in_ready);
      end
    end
    @(negedge clk);
    pd.in_valid = 1'b1;
    pd.in_data = cdin[2];
    #1;
    checks++;
    if (pd.in_ready !== 1'b0) begin
      errors++; $display("FAIL bubble_full: got %b expected 0", pd.in_ready);
    end
    pd.in_valid = 1'b0;
    pd.in_data = '0;
    pd.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (pd.out_valid === 1'b1) begin
        checks++;
        if (rx >= 3 || obs !== cexp[order[rx % 3]]) begin
          errors++; $display("FAIL bubble_drain[%0d]: got %h expected %h", rx, obs, cexp[order[rx % 3]]);
        end
        rx++;
      end
      @(negedge clk);
    end
    checks++;
    if (rx !== 3) begin
      errors++; $display("FAIL bubble_count: got %0d expected 3", rx);
    end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    int nout = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      pd.out_ready = 1'b0;
      pd.in_valid = 1'b1;
      pd.in_data = cdin[c + 3];
    end
    @(negedge clk);
    pd.in_valid = 1'b0;
    pd.in_data = '0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (pd.out_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_out_valid: got %b expected 0", pd.out_valid);
    end
    checks++;
    if (obs !== 21'h0) begin
      errors++; $display("FAIL rstmid_outputs: got %h expected 000000", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    pd.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (pd.out_valid === 1'b1) begin
        nout++;
        if (first < 0) first = c;
        checks++;
        if (obs !== cexp[1]) begin
          errors++; $display("FAIL rstmid_data: got %h expected %h", obs, cexp[1]);
        end
      end
      pd.in_valid = (c == 0);
      pd.in_data = (c == 0) ? cdin[1] : 16'h0;
    end
    checks++;
    if (first !== 3) begin
      errors++; $display("FAIL rstmid_latency: got cycle %0d expected 3", first);
    end
    checks++;
    if (nout !== 1) begin
      errors++; $display("FAIL rstmid_count: got %0d expected 1", nout);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    init_corpus();
    test_reset();
    test_corpus();
    test_back_to_back();
    test_backpressure();
    test_bubble();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/posit_decoder_pipe.md
Name: posit_decoder_pipe

Overview:
- Parametrised, pipelined posit decoder. Splits an N-bit posit into sign, signed regime, exponent and left-aligned fraction, and flags zero and NaR.
- Successor to the fixed 64/4 combinational decoder. Adds a 3-stage registered pipeline with valid/ready flow control on both sides, and bubble collapse.
- Feeds the posit arithmetic datapath (adder/multiplier front-ends).

Parameters:
- N, 64, posit width in bits (N >= 8).
- ES, 4, exponent field size (0 <= ES <= N-5).
- RS, $clog2(N)+1, signed regime output width.
- FS, N-ES-3, fraction output width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- in_data  input  N  posit operand.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand this cycle.
- out_sign  output  1  posit sign bit.
- out_regime  output  RS  signed regime value k.
- out_exp  output  ES  exponent field.
- out_frac  output  FS  fraction field, left-aligned, hidden bit excluded.
- out_zero  output  1  operand was all zeros.
- out_nar  output  1  operand was NaR (1 followed by N-1 zeros).
- out_valid  output  1  output bundle valid.
- out_ready  input  1  downstream accepts the bundle.

Behaviour:
- Reset: clocking is a single clk domain. rst is asynchronous and active-high.
  - While rst is high, all stage valid bits are 0 and all data registers are 0.
  - Every output is 0, except in_ready. in_ready is 1 whenever stage 1 can load, so it is 1 once rst deasserts.
  - rst asserted mid-operation discards all in-flight operands. No output is produced for them.
- Stages:
  - S1 registers sign = in_data[N-1], body = two's complement of in_data when sign=1 (low N-1 bits kept), zero and nar flags.
  - S2 performs leading-run detection on body[N-2:0]. Run length m counts identical bits from bit N-2 down.
    - If the first bit is 1: k = m-1. Otherwise: k = -m.
    - S2 registers k, and the remaining bits shifted left by m+1 (run plus terminating bit).
  - S3 splits the shifted bits: top ES bits become exp, next FS bits become frac. Bits shifted in are 0, so truncated exp/frac fields read as zero-padded.
- Latency: 3 cycles from accepted input to out_valid when there is no backpressure. Throughput is 1 operand per cycle.
- Handshake:
  - A transfer occurs when valid and ready are both 1 on a clock edge.
  - en3 = !v3 | out_ready; en2 = !v2 | en3; en1 = !v1 | en2; in_ready = en1 (combinational chain).
  - Bubbles collapse: a stage loads whenever it is empty, even if downstream is stalled.
  - While out_valid=1 and out_ready=0, all out_* signals hold stable.
  - in_data is ignored when in_valid=0. A stage loaded with no valid input clears its valid bit.
- Special cases:
  - in_data = 0: out_zero=1, sign=0, regime=0, exp=0, frac=0.
  - in_data = 1<<(N-1): out_nar=1, sign=1, regime=0, exp=0, frac=0.
  - out_zero and out_nar are never both 1.
- Regime extremes:
  - Largest magnitude (0111…1): k = N-2.
  - Smallest magnitude (000…01): k = -(N-2).
  - RS always holds ±(N-2) without overflow.
- Simultaneous events: an output transfer and an input acceptance in the same cycle both occur. Occupancy never exceeds 3 and no operand is dropped or duplicated.

Test Plan:
All vectors use N=16, ES=1 (RS=5, FS=12).
- Decode corpus:
  - 0x4000 -> sign0, k=0, exp0, frac 0x000.
  - 0x5A00 -> sign0, k=0, exp1, frac 0xA00.
  - 0x7FFF -> k=14, exp0, frac0.
  - 0x0001 -> k=-14, exp0, frac0.
  - 0xC000 -> sign1, k=0, exp0, frac0.
- Specials:
  - 0x0000 -> out_zero=1, all other fields 0.
  - 0x8000 -> out_nar=1, sign1, other fields 0.
- Streaming: 8 back-to-back valid inputs with out_ready=1 -> first out_valid 3 cycles after the first accept, then one result per cycle in order, with in_ready constantly 1.
- Backpressure: hold out_ready=0 for 6 cycles while driving inputs -> exactly 3 operands are accepted, then in_ready=0 and the outputs hold stable. Releasing out_ready -> all 3 drain in order with no loss.
- Bubble collapse: accept A, idle 2 cycles, accept B, with out_ready=0 -> in_ready stays 1 until 3 operands are stored.
- Reset mid-stream: assert rst asynchronously between edges while 3 operands are in flight -> out_valid=0 immediately. After deassertion, the first new input appears 3 cycles after acceptance and no stale data is emitted.
